pe_config: RTL and testbench

//  Sequencer for the EKF-SLAM systolic PE array and its buffers.
//  - Takes one-hot stage requests (PRD/NEW/UPD) and handshakes with the nonlinear unit.
//  - Then runs a fixed 3x3 matrix-multiply schedule: drives PE-array input/output selects, TB (temp buffer) and CB (covariance buffer) dual-port BRAM controls.

---
 rtl/pe_config.sv | 203 ++++++++++++++++++++
 tb/tb_pe_config.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_config.sv
// Sequencer for the EKF-SLAM PE array: stage handshake plus a fixed 3x3 matmul BRAM/PE schedule.
// Optional macro NL_TIMEOUT_EN aborts a stalled nonlinear-unit handshake after 64 cycles.
module pe_config #(
    parameter int X          = 4,
    parameter int Y          = 4,
    parameter int L          = 4,
    parameter int RSA_DW     = 32,
    parameter int TB_AW      = 11,
    parameter int CB_AW      = 17,
    parameter int SEQ_CNT_DW = 500,
    parameter int N          = 3,
    parameter int RD_DELAY   = 3,
    parameter int WR_DELAY   = 1,
    parameter int F_xi       = 0,
    parameter int t_cov      = 6,
    parameter int F_cov      = 9
) (
    input  logic                  clk,
    input  logic                  sys_rst,
    input  logic [2:0]            stage_val,
    input  logic [2:0]            nonlinear_s_val,
    input  logic [2:0]            nonlinear_s_rdy,
    output logic [2:0]            stage_rdy,
    output logic [2:0]            nonlinear_m_rdy,
    output logic [2:0]            nonlinear_m_val,
    output logic [X-1:0]          A_in_sel,
    output logic [X-1:0]          A_in_en,
    output logic [2*Y-1:0]        B_in_sel,
    output logic [Y-1:0]          B_in_en,
    output logic [2*X-1:0]        M_in_sel,
    output logic [X-1:0]          M_in_en,
    output logic [2*X-1:0]        C_out_sel,
    output logic [X-1:0]          C_out_en,
    output logic [L-1:0]          TB_dinb_sel,
    output logic [L-1:0]          TB_douta_sel,
    output logic [L-1:0]          TB_doutb_sel,
    output logic [L-1:0]          TB_ena,
    output logic [L-1:0]          TB_enb,
    output logic [L-1:0]          TB_wea,
    output logic [L-1:0]          TB_web,
    output logic [L-1:0]          CB_dinb_sel,
    output logic [L-1:0]          CB_douta_sel,
    output logic [L-1:0]          CB_doutb_sel,
    output logic [L-1:0]          CB_ena,
    output logic [L-1:0]          CB_enb,
    output logic [L-1:0]          CB_wea,
    output logic [L-1:0]          CB_web,
    output logic [L*RSA_DW-1:0]   TB_dina,
    output logic [L*RSA_DW-1:0]   CB_dina,
    output logic [L*TB_AW-1:0]    TB_addra,
    output logic [L*TB_AW-1:0]    TB_addrb,
    output logic [L*CB_AW-1:0]    CB_addra,
    output logic [L*CB_AW-1:0]    CB_addrb,
    output logic                  new_cal_en,
    output logic                  new_cal_done
);

    localparam int CNT_W  = $clog2(SEQ_CNT_DW + 1);
    localparam int T_OUT0 = RD_DELAY + N + X;
    localparam int T_WB0  = T_OUT0 + WR_DELAY;
    localparam int T_LAST = T_WB0 + N - 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_NL_WAIT = 2'd1;
    localparam logic [1:0] S_MAT     = 2'd2;
    localparam logic [1:0] S_HANDOFF = 2'd3;

    logic [1:0]       r_state;
    logic [2:0]       r_kOh;
    logic [CNT_W-1:0] r_t;
    logic             r_flag;
    logic             r_newDone;
    logic             w_oneHot;
    logic             w_sVal;
    logic             w_sRdy;
    logic [31:0]      w_t;
`ifdef NL_TIMEOUT_EN
    logic [5:0]       r_tmo;
`endif

    // The stage is held one-hot so per-stage handshake bits are simple masks.
    assign w_oneHot = (stage_val == 3'b001) || (stage_val == 3'b010) || (stage_val == 3'b100);
    assign w_sVal   = |(nonlinear_s_val & r_kOh);
    assign w_sRdy   = |(nonlinear_s_rdy & r_kOh);
    assign w_t      = 32'(r_t);

    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state   <= S_IDLE;
            r_kOh     <= 3'b000;
            r_t       <= '0;
            r_flag    <= 1'b0;
            r_newDone <= 1'b0;
`ifdef NL_TIMEOUT_EN
            r_tmo     <= '0;
`endif
        end else begin
            r_newDone <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_oneHot) begin
                        r_state <= S_NL_WAIT;
                        r_kOh   <= stage_val;
`ifdef NL_TIMEOUT_EN
                        r_tmo   <= '0;
`endif
                    end
                end
                S_NL_WAIT: begin
                    if (w_sVal) begin
                        r_state <= S_MAT;
                        r_t     <= '0;
                        r_flag  <= 1'b0;
                    end
`ifdef NL_TIMEOUT_EN
                    else if (r_tmo == 6'd63) r_state <= S_IDLE;
                    else r_tmo <= r_tmo + 6'd1;
`endif
                end
                S_MAT: begin
                    if (w_sRdy) r_flag <= 1'b1;
                    if (r_t == CNT_W'(T_LAST)) begin
                        r_state <= S_HANDOFF;
`ifdef NL_TIMEOUT_EN
                        r_tmo   <= '0;
`endif
                    end else begin
                        r_t <= r_t + CNT_W'(1);
                    end
                end
                default: begin
                    if (r_flag || w_sRdy) begin
                        r_state   <= S_IDLE;
                        r_newDone <= r_kOh[1];
                    end
`ifdef NL_TIMEOUT_EN
                    else if (r_tmo == 6'd63) r_state <= S_IDLE;
                    else r_tmo <= r_tmo + 6'd1;
`endif
                end
            endcase
        end
    end

    assign A_in_sel     = '0;
    assign B_in_sel     = '0;
    assign M_in_sel     = '0;
    assign M_in_en      = '0;
    assign C_out_sel    = '0;
    assign TB_dinb_sel  = '0;
    assign TB_douta_sel = '0;
    assign TB_doutb_sel = '0;
    assign TB_enb       = '0;
    assign TB_wea       = '0;
    assign TB_web       = '0;
    assign TB_addrb     = '0;
    assign CB_dinb_sel  = '0;
    assign CB_douta_sel = '0;
    assign CB_doutb_sel = '0;
    assign CB_wea       = '0;
    assign TB_dina      = '0;
    assign CB_dina      = '0;
    assign new_cal_done = r_newDone;

    // Schedule decode: lane i of each phase is offset by i cycles from lane 0.
    always_comb begin
        stage_rdy       = (r_state == S_IDLE) ? 3'b111 : 3'b000;
        nonlinear_m_rdy = (r_state == S_NL_WAIT) ? r_kOh : 3'b000;
        nonlinear_m_val = (r_state == S_HANDOFF) ? r_kOh : 3'b000;
        new_cal_en      = (r_state == S_MAT) && r_kOh[1];
        A_in_en         = '0;
        B_in_en         = '0;
        C_out_en        = '0;
        TB_ena          = '0;
        TB_addra        = '0;
        CB_ena          = '0;
        CB_addra        = '0;
        CB_enb          = '0;
        CB_web          = '0;
        CB_addrb        = '0;
        if (r_state == S_MAT) begin
            for (int i = 0; i < N; i++) begin
                if (w_t < N) begin
                    TB_ena[i]                  = 1'b1;
                    TB_addra[i*TB_AW +: TB_AW] = TB_AW'(F_xi + w_t);
                    CB_ena[i]                  = 1'b1;
                    CB_addra[i*CB_AW +: CB_AW] = CB_AW'(t_cov + w_t);
                end
                if ((w_t >= RD_DELAY + i) && (w_t <= RD_DELAY + i + N - 1)) begin
                    A_in_en[i] = 1'b1;
                    B_in_en[i] = 1'b1;
                end
                if (w_t == T_OUT0 + i) C_out_en[i] = 1'b1;
                if (w_t == T_WB0 + i) begin
                    CB_enb[i]                  = 1'b1;
                    CB_web[i]                  = 1'b1;
                    CB_addrb[i*CB_AW +: CB_AW] = CB_AW'(F_cov + i);
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_config.sv
// Self-checking bench for pe_config: table of stage requests plus reset and timeout sequences.
// Expected output snapshots are queued as stimulus is driven and popped at the following negedge.
module tb_pe_config;

    logic         clk = 1'b0;
    logic         sys_rst;
    logic [2:0]   stage_val, nonlinear_s_val, nonlinear_s_rdy;
    logic [2:0]   stage_rdy, nonlinear_m_rdy, nonlinear_m_val;
    logic [3:0]   A_in_sel, A_in_en, B_in_en, M_in_en, C_out_en;
    logic [7:0]   B_in_sel, M_in_sel, C_out_sel;
    logic [3:0]   TB_dinb_sel, TB_douta_sel, TB_doutb_sel, TB_ena, TB_enb, TB_wea, TB_web;
    logic [3:0]   CB_dinb_sel, CB_douta_sel, CB_doutb_sel, CB_ena, CB_enb, CB_wea, CB_web;
    logic [127:0] TB_dina, CB_dina;
    logic [43:0]  TB_addra, TB_addrb;
    logic [67:0]  CB_addra, CB_addrb;
    logic         new_cal_en, new_cal_done;

    pe_config dut (
        .clk(clk), .sys_rst(sys_rst), .stage_val(stage_val),
        .nonlinear_s_val(nonlinear_s_val), .nonlinear_s_rdy(nonlinear_s_rdy),
        .stage_rdy(stage_rdy), .nonlinear_m_rdy(nonlinear_m_rdy), .nonlinear_m_val(nonlinear_m_val),
        .A_in_sel(A_in_sel), .A_in_en(A_in_en), .B_in_sel(B_in_sel), .B_in_en(B_in_en),
        .M_in_sel(M_in_sel), .M_in_en(M_in_en), .C_out_sel(C_out_sel), .C_out_en(C_out_en),
        .TB_dinb_sel(TB_dinb_sel), .TB_douta_sel(TB_douta_sel), .TB_doutb_sel(TB_doutb_sel),
        .TB_ena(TB_ena), .TB_enb(TB_enb), .TB_wea(TB_wea), .TB_web(TB_web),
        .CB_dinb_sel(CB_dinb_sel), .CB_douta_sel(CB_douta_sel), .CB_doutb_sel(CB_doutb_sel),
        .CB_ena(CB_ena), .CB_enb(CB_enb), .CB_wea(CB_wea), .CB_web(CB_web),
        .TB_dina(TB_dina), .CB_dina(CB_dina), .TB_addra(TB_addra), .TB_addrb(TB_addrb),
        .CB_addra(CB_addra), .CB_addrb(CB_addrb),
        .new_cal_en(new_cal_en), .new_cal_done(new_cal_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  stageRdy, mRdy, mVal;
        logic        newEn, newDone;
        logic [3:0]  tbEna, cbEna, aEn, bEn, cEn, cbEnb, cbWeb;
        logic [43:0] tbAddra;
        logic [67:0] cbAddra, cbAddrb;
        logic        constBad;
    } snap_t;

    typedef struct {
        logic [2:0] sv;
        int         waitCyc;
        int         rdyT;
        bit         accept;
        string      tag;
    } vec_t;

    snap_t expQ[$];
    int    nVec = 0;
    int    nMiss = 0;
    vec_t  vecs[8];

    function automatic snap_t idleSnap(input logic done);
        snap_t s = '0;
        s.stageRdy = 3'b111;
        s.newDone  = done;
        return s;
    endfunction

    function automatic snap_t waitSnap(input logic [2:0] oh);
        snap_t s = '0;
        s.mRdy = oh;
        return s;
    endfunction

    function automatic snap_t handSnap(input logic [2:0] oh);
        snap_t s = '0;
        s.mVal = oh;
        return s;
    endfunction

    // Matmul timing at default parameters: reads t=0..2, feed 3+i..5+i, out 10+i, write 11+i.
    function automatic snap_t matSnap(input logic [2:0] oh, input int t);
        snap_t s = '0;
        s.newEn = oh[1];
        for (int i = 0; i < 3; i++) begin
            if (t <= 2) begin
                s.tbEna[i]             = 1'b1;
                s.tbAddra[i*11 +: 11]  = 11'(t);
                s.cbEna[i]             = 1'b1;
                s.cbAddra[i*17 +: 17]  = 17'(6 + t);
            end
            s.aEn[i] = (t >= 3 + i) && (t <= 5 + i);
            s.bEn[i] = (t >= 3 + i) && (t <= 5 + i);
            s.cEn[i] = (t == 10 + i);
            if (t == 11 + i) begin
                s.cbEnb[i]            = 1'b1;
                s.cbWeb[i]            = 1'b1;
                s.cbAddrb[i*17 +: 17] = 17'(9 + i);
            end
        end
        return s;
    endfunction

    function automatic snap_t getSnap();
        snap_t s;
        s.stageRdy = stage_rdy;
        s.mRdy     = nonlinear_m_rdy;
        s.mVal     = nonlinear_m_val;
        s.newEn    = new_cal_en;
        s.newDone  = new_cal_done;
        s.tbEna    = TB_ena;
        s.cbEna    = CB_ena;
        s.aEn      = A_in_en;
        s.bEn      = B_in_en;
        s.cEn      = C_out_en;
        s.cbEnb    = CB_enb;
        s.cbWeb    = CB_web;
        s.tbAddra  = TB_addra;
        s.cbAddra  = CB_addra;
        s.cbAddrb  = CB_addrb;
        s.constBad = |{A_in_sel, B_in_sel, M_in_sel, M_in_en, C_out_sel, TB_dinb_sel, TB_douta_sel,
                       TB_doutb_sel, TB_enb, TB_wea, TB_web, CB_dinb_sel, CB_douta_sel,
                       CB_doutb_sel, CB_wea, TB_dina, CB_dina, TB_addrb};
        return s;
    endfunction

    task automatic checkNow(input snap_t exp, input string name);
        snap_t act = getSnap();
        nVec++;
        if (act !== exp) begin
            nMiss++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Queue the expected snapshot for the state after the next rising edge, then advance.
    task automatic applyStimulus(input snap_t exp);
        expQ.push_back(exp);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name);
        snap_t exp;
        if (expQ.size() == 0) begin
            nVec++;
            nMiss++;
            $display("[TB] FAIL %s: scoreboard empty", name);
        end else begin
            exp = expQ.pop_front();
            checkNow(exp, name);
        end
    endtask

    task automatic step(input snap_t exp, input string name);
        applyStimulus(exp);
        checkOutput(name);
    endtask

    task automatic runTxn(input logic [2:0] sv, input int waitCyc, input int rdyT, input string tag);
        stage_val = sv;
        step(waitSnap(sv), {tag, "_accept"});
        for (int c = 1; c < waitCyc; c++) begin
            if (c == 2) stage_val = 3'b000;
            step(waitSnap(sv), {tag, "_wait"});
        end
        stage_val       = 3'b000;
        nonlinear_s_val = sv;
        step(matSnap(sv, 0), {tag, "_mat0"});
        nonlinear_s_val = 3'b000;
        for (int t = 1; t <= 13; t++) begin
            nonlinear_s_rdy = (t == rdyT) ? sv : 3'b000;
            stage_val       = (t == 5 || t == 6) ? 3'b100 : 3'b000;
            step(matSnap(sv, t), $sformatf("%s_mat%0d", tag, t));
        end
        nonlinear_s_rdy = 3'b000;
        stage_val       = 3'b000;
        step(handSnap(sv), {tag, "_handoff"});
        if (rdyT <= 0) begin
            step(handSnap(sv), {tag, "_handoff_hold1"});
            step(handSnap(sv), {tag, "_handoff_hold2"});
            nonlinear_s_rdy = sv;
        end
        step(idleSnap(sv[1]), {tag, "_done"});
        nonlinear_s_rdy = 3'b000;
        step(idleSnap(1'b0), {tag, "_idle"});
    endtask

    initial begin
        vecs[0] = '{3'b001, 5, 10, 1'b1, "prd"};
        vecs[1] = '{3'b010, 3, 4, 1'b1, "new"};
        vecs[2] = '{3'b011, 0, 0, 1'b0, "rej011"};
        vecs[3] = '{3'b000, 0, 0, 1'b0, "rej000"};
        vecs[4] = '{3'b100, 2, -1, 1'b1, "upd_live"};
        vecs[5] = '{3'b110, 0, 0, 1'b0, "rej110"};
        vecs[6] = '{3'b010, 1, -1, 1'b1, "new_live"};
        vecs[7] = '{3'b111, 0, 0, 1'b0, "rej111"};

        sys_rst         = 1'b0;
        stage_val       = 3'b000;
        nonlinear_s_val = 3'b000;
        nonlinear_s_rdy = 3'b000;
        @(negedge clk);
        checkNow(idleSnap(1'b0), "reset_start");
        repeat (14) @(negedge clk);
        checkNow(idleSnap(1'b0), "reset_end");
        sys_rst = 1'b1;
        step(idleSnap(1'b0), "after_reset");

        for (int v = 0; v < 8; v++) begin
            if (vecs[v].accept) begin
                runTxn(vecs[v].sv, vecs[v].waitCyc, vecs[v].rdyT, vecs[v].tag);
            end else begin
                stage_val = vecs[v].sv;
                for (int c = 0; c < 3; c++) step(idleSnap(1'b0), vecs[v].tag);
                stage_val = 3'b000;
            end
        end

        // Asynchronous reset in the middle of the matmul schedule.
        stage_val = 3'b001;
        step(waitSnap(3'b001), "rst_accept");
        stage_val       = 3'b000;
        nonlinear_s_val = 3'b001;
        step(matSnap(3'b001, 0), "rst_mat0");
        nonlinear_s_val = 3'b000;
        for (int t = 1; t <= 5; t++) step(matSnap(3'b001, t), $sformatf("rst_mat%0d", t));
        #2 sys_rst = 1'b0;
        #1 checkNow(idleSnap(1'b0), "rst_async");
        @(posedge clk);
        @(negedge clk);
        checkNow(idleSnap(1'b0), "rst_held");
        sys_rst = 1'b1;
        step(idleSnap(1'b0), "rst_release");
        runTxn(3'b001, 2, 2, "post_rst");

`ifdef NL_TIMEOUT_EN
        stage_val = 3'b001;
        step(waitSnap(3'b001), "tmo_accept");
        stage_val = 3'b000;
        for (int c = 2; c <= 64; c++) step(waitSnap(3'b001), "tmo_wait");
        step(idleSnap(1'b0), "tmo_abort");
        step(idleSnap(1'b0), "tmo_idle");
`else
        runTxn(3'b001, 70, 3, "long_wait");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
